sync_sp_ram_rmw_ctrl: RTL and testbench

SYNC_SP_RAM_RMW_CTRL -- requirements
Module: sync_sp_ram_rmw_ctrl

---
 rtl/sync_sp_ram_pkg.sv | 16 +
 rtl/sync_sp_ram_be_merge.sv | 21 ++
 rtl/sync_sp_ram_rmw_ctrl.sv | 131 +++++++++++++
 tb/tb_sync_sp_ram_rmw_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_sp_ram_pkg.sv
// Shared types and default geometry for the single-port RAM read-modify-write controller.
// Holds the controller state encoding so the top and the bench agree on it.
package sync_sp_ram_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned DATA_WIDTH_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } state_e;

endpackage

// File: rtl/sync_sp_ram_be_merge.sv
// Combinational per-byte merge: enabled bytes come from the new word, the rest from the old word.
// Zero latency, no flow control.
module sync_sp_ram_be_merge #(
    parameter int unsigned DataWidth = 64
) (
    input  logic [DataWidth-1:0]   i_old_dat,
    input  logic [DataWidth-1:0]   i_new_dat,
    input  logic [DataWidth/8-1:0] i_be,
    output logic [DataWidth-1:0]   o_merged_dat
);

    always_comb begin
        o_merged_dat = i_old_dat;
        for (int i = 0; i < DataWidth/8; i++) begin
            if (i_be[i]) begin
                o_merged_dat[i*8 +: 8] = i_new_dat[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/sync_sp_ram_rmw_ctrl.sv
// One-at-a-time request front end for a single-port RAM without byte enables; partial writes become read-merge-write.
// Read: response 3 cycles after accept; full write 2 cycles; partial write 4 cycles; Req_RO only in IDLE, RSP holds until Rsp_RI.
module sync_sp_ram_rmw_ctrl
    import sync_sp_ram_pkg::*;
#(
    parameter int unsigned AddrWidth = ADDR_WIDTH_DEF,
    parameter int unsigned DataWidth = DATA_WIDTH_DEF
) (
    input  logic                   Clk_CI,
    input  logic                   Rst_RI,
    input  logic                   Req_VI,
    output logic                   Req_RO,
    input  logic                   ReqWe_SI,
    input  logic [AddrWidth-1:0]   ReqAddr_DI,
    input  logic [DataWidth/8-1:0] ReqBe_SI,
    input  logic [DataWidth-1:0]   ReqWData_DI,
    output logic                   Rsp_VO,
    input  logic                   Rsp_RI,
    output logic [DataWidth-1:0]   RspRData_DO,
    output logic                   CSel_SO,
    output logic                   WrEn_SO,
    output logic [AddrWidth-1:0]   Addr_DO,
    output logic [DataWidth-1:0]   WrData_DO,
    output logic [DataWidth/8-1:0] BEn_SO,
    input  logic [DataWidth-1:0]   RdData_DI
);

    localparam int unsigned BeWidth = DataWidth / 8;

    state_e               r_state;
    logic                 r_we;
    logic [BeWidth-1:0]   r_be;
    logic [DataWidth-1:0] r_wdata;
    logic                 r_csel;
    logic                 r_wren;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_ram_wdata;
    logic                 r_rsp_vld;
    logic [DataWidth-1:0] r_rsp_data;
    logic [DataWidth-1:0] w_merged;

    sync_sp_ram_be_merge #(
        .DataWidth (DataWidth)
    ) u_be_merge (
        .i_old_dat    (RdData_DI),
        .i_new_dat    (r_wdata),
        .i_be         (r_be),
        .o_merged_dat (w_merged)
    );

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_csel      <= 1'b0;
            r_wren      <= 1'b0;
            r_addr      <= '0;
            r_ram_wdata <= '0;
            r_rsp_vld   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Req_VI) begin
                        r_we    <= ReqWe_SI;
                        r_be    <= ReqBe_SI;
                        r_wdata <= ReqWData_DI;
                        if (ReqWe_SI && (&ReqBe_SI)) begin
                            r_state     <= ST_WR;
                            r_csel      <= 1'b1;
                            r_wren      <= 1'b1;
                            r_addr      <= ReqAddr_DI;
                            r_ram_wdata <= ReqWData_DI;
                        end else if (!(ReqWe_SI && !(|ReqBe_SI))) begin
                            // Reads and partial writes both start with a RAM read.
                            r_state <= ST_RD;
                            r_csel  <= 1'b1;
                            r_wren  <= 1'b0;
                            r_addr  <= ReqAddr_DI;
                        end
                    end
                end
                ST_RD: begin
                    r_state <= ST_WAIT;
                    r_csel  <= 1'b0;
                    r_wren  <= 1'b0;
                end
                ST_WAIT: begin
                    if (r_we) begin
                        r_state     <= ST_WR;
                        r_csel      <= 1'b1;
                        r_wren      <= 1'b1;
                        r_ram_wdata <= w_merged;
                    end else begin
                        r_state    <= ST_RSP;
                        r_rsp_vld  <= 1'b1;
                        r_rsp_data <= RdData_DI;
                    end
                end
                ST_WR: begin
                    r_state <= ST_IDLE;
                    r_csel  <= 1'b0;
                    r_wren  <= 1'b0;
                end
                ST_RSP: begin
                    if (Rsp_RI) begin
                        r_state   <= ST_IDLE;
                        r_rsp_vld <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_csel  <= 1'b0;
                    r_wren  <= 1'b0;
                end
            endcase
        end
    end

    assign Req_RO      = (r_state == ST_IDLE);
    assign Rsp_VO      = r_rsp_vld;
    assign RspRData_DO = r_rsp_data;
    assign CSel_SO     = r_csel;
    assign WrEn_SO     = r_wren;
    assign Addr_DO     = r_addr;
    assign WrData_DO   = r_ram_wdata;
    assign BEn_SO      = '1;

endmodule

// File: tb/tb_sync_sp_ram_rmw_ctrl.sv
// Directed bench for sync_sp_ram_rmw_ctrl with a behavioural single-port RAM.
module tb_sync_sp_ram_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_v;
    logic        req_r;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [7:0]  req_be;
    logic [63:0] req_wdata;
    logic        rsp_v;
    logic        rsp_r;
    logic [63:0] rsp_data;
    logic        csel;
    logic        wren;
    logic [7:0]  ram_addr;
    logic [63:0] ram_wdata;
    logic [7:0]  ram_ben;
    logic [63:0] ram_rdata;

    logic [63:0] mem [256];
    logic        pre_vld = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [63:0] pre_dat = '0;
    int          cs_cnt = 0;
    int          wr_cnt = 0;
    int          total = 0;
    int          bad = 0;
    int          cs_snap;
    int          wr_snap;

    always #5 clk = ~clk;

    sync_sp_ram_rmw_ctrl dut (
        .Clk_CI      (clk),
        .Rst_RI      (rst),
        .Req_VI      (req_v),
        .Req_RO      (req_r),
        .ReqWe_SI    (req_we),
        .ReqAddr_DI  (req_addr),
        .ReqBe_SI    (req_be),
        .ReqWData_DI (req_wdata),
        .Rsp_VO      (rsp_v),
        .Rsp_RI      (rsp_r),
        .RspRData_DO (rsp_data),
        .CSel_SO     (csel),
        .WrEn_SO     (wren),
        .Addr_DO     (ram_addr),
        .WrData_DO   (ram_wdata),
        .BEn_SO      (ram_ben),
        .RdData_DI   (ram_rdata)
    );

    // RAM model ignores byte enables; preload port lets the bench seed words.
    always @(posedge clk) begin
        if (pre_vld) begin
            mem[pre_addr] <= pre_dat;
        end
        if (csel) begin
            cs_cnt <= cs_cnt + 1;
            if (wren) begin
                mem[ram_addr] <= ram_wdata;
                wr_cnt        <= wr_cnt + 1;
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [63:0] d);
        pre_vld  = 1'b1;
        pre_addr = a;
        pre_dat  = d;
        tick();
        pre_vld  = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] be, input logic [63:0] d);
        req_v     = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_be    = be;
        req_wdata = d;
        tick();
        req_v     = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_v     = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        rsp_r     = 1'b0;
        repeat (2) tick();
        preload(8'h10, 64'h0123456789ABCDEF);
        preload(8'h05, 64'hFFFFFFFFFFFFFFFF);
        preload(8'h07, 64'h1122334455667788);
        rst = 1'b0;

        chk_b("rst_req_r", req_r, 1'b1);
        chk_b("rst_csel", csel, 1'b0);
        chk_b("rst_wren", wren, 1'b0);
        chk_b("rst_rsp_v", rsp_v, 1'b0);
        chk_d("rst_addr", 64'(ram_addr), 64'h0);
        chk_d("rst_wdata", ram_wdata, 64'h0);
        chk_d("rst_rdata", rsp_data, 64'h0);
        chk_d("ben_ones", 64'(ram_ben), 64'hFF);

        // Read of 0x10, then 5 cycles of response backpressure.
        issue(1'b0, 8'h10, 8'h00, 64'h0);
        chk_b("rd_n1_csel", csel, 1'b1);
        chk_b("rd_n1_wren", wren, 1'b0);
        chk_d("rd_n1_addr", 64'(ram_addr), 64'h10);
        chk_b("rd_n1_req_r", req_r, 1'b0);
        tick();
        chk_b("rd_n2_csel", csel, 1'b0);
        chk_b("rd_n2_rsp_v", rsp_v, 1'b0);
        tick();
        chk_b("rd_n3_rsp_v", rsp_v, 1'b1);
        chk_d("rd_n3_data", rsp_data, 64'h0123456789ABCDEF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_b("bp_rsp_v", rsp_v, 1'b1);
            chk_d("bp_data", rsp_data, 64'h0123456789ABCDEF);
            chk_b("bp_req_r", req_r, 1'b0);
            chk_b("bp_csel", csel, 1'b0);
        end
        rsp_r = 1'b1;
        tick();
        rsp_r = 1'b0;
        chk_b("bp_done_rsp_v", rsp_v, 1'b0);
        chk_b("bp_done_req_r", req_r, 1'b1);

        // Partial write: low four bytes cleared in an all-ones word.
        cs_snap = cs_cnt;
        wr_snap = wr_cnt;
        issue(1'b1, 8'h05, 8'h0F, 64'h0);
        chk_b("pw_n1_csel", csel, 1'b1);
        chk_b("pw_n1_wren", wren, 1'b0);
        chk_d("pw_n1_addr", 64'(ram_addr), 64'h05);
        tick();
        chk_b("pw_n2_csel", csel, 1'b0);
        chk_d("pw_n2_addr", 64'(ram_addr), 64'h05);
        tick();
        chk_b("pw_n3_csel", csel, 1'b1);
        chk_b("pw_n3_wren", wren, 1'b1);
        chk_d("pw_n3_addr", 64'(ram_addr), 64'h05);
        chk_d("pw_n3_wdata", ram_wdata, 64'hFFFFFFFF00000000);
        chk_b("pw_n3_req_r", req_r, 1'b0);
        tick();
        chk_b("pw_n4_req_r", req_r, 1'b1);
        chk_b("pw_n4_csel", csel, 1'b0);
        chk_b("pw_rsp_v", rsp_v, 1'b0);
        chk_d("pw_mem", mem[8'h05], 64'hFFFFFFFF00000000);
        chk_d("pw_cs_cnt", 64'(cs_cnt - cs_snap), 64'd2);
        chk_d("pw_wr_cnt", 64'(wr_cnt - wr_snap), 64'd1);

        // Full write to the top address, then read it back.
        wr_snap = wr_cnt;
        issue(1'b1, 8'hFF, 8'hFF, 64'hA5A5A5A5A5A5A5A5);
        chk_b("fw_n1_csel", csel, 1'b1);
        chk_b("fw_n1_wren", wren, 1'b1);
        chk_d("fw_n1_addr", 64'(ram_addr), 64'hFF);
        chk_d("fw_n1_wdata", ram_wdata, 64'hA5A5A5A5A5A5A5A5);
        chk_b("fw_n1_req_r", req_r, 1'b0);
        tick();
        chk_b("fw_n2_req_r", req_r, 1'b1);
        chk_b("fw_n2_wren", wren, 1'b0);
        chk_d("fw_wr_cnt", 64'(wr_cnt - wr_snap), 64'd1);
        issue(1'b0, 8'hFF, 8'h00, 64'h0);
        tick();
        tick();
        chk_b("fw_rd_rsp_v", rsp_v, 1'b1);
        chk_d("fw_rd_data", rsp_data, 64'hA5A5A5A5A5A5A5A5);
        rsp_r = 1'b1;
        tick();
        rsp_r = 1'b0;
        chk_b("fw_rd_done", req_r, 1'b1);

        // Zero-enable write completes in place; a read follows back-to-back.
        cs_snap = cs_cnt;
        issue(1'b1, 8'h03, 8'h00, 64'hDEADBEEFDEADBEEF);
        chk_b("zw_req_r", req_r, 1'b1);
        chk_b("zw_csel", csel, 1'b0);
        issue(1'b0, 8'h10, 8'h00, 64'h0);
        chk_b("zw_b2b_csel", csel, 1'b1);
        chk_d("zw_b2b_addr", 64'(ram_addr), 64'h10);
        tick();
        tick();
        chk_b("zw_b2b_rsp_v", rsp_v, 1'b1);
        chk_d("zw_b2b_data", rsp_data, 64'h0123456789ABCDEF);
        rsp_r = 1'b1;
        tick();
        rsp_r = 1'b0;
        chk_d("zw_cs_cnt", 64'(cs_cnt - cs_snap), 64'd1);

        // Reset while a partial write waits on its read data.
        wr_snap = wr_cnt;
        issue(1'b1, 8'h07, 8'hF0, 64'h0);
        tick();
        rst = 1'b1;
        tick();
        chk_b("ra_csel", csel, 1'b0);
        chk_b("ra_wren", wren, 1'b0);
        chk_b("ra_rsp_v", rsp_v, 1'b0);
        chk_d("ra_addr", 64'(ram_addr), 64'h0);
        chk_d("ra_wdata", ram_wdata, 64'h0);
        chk_d("ra_rdata", rsp_data, 64'h0);
        rst = 1'b0;
        chk_b("ra_req_r", req_r, 1'b1);
        repeat (4) tick();
        chk_d("ra_wr_cnt", 64'(wr_cnt - wr_snap), 64'd0);
        chk_d("ra_mem", mem[8'h07], 64'h1122334455667788);
        chk_b("ra_rsp_v_late", rsp_v, 1'b0);
        chk_b("ra_req_r_late", req_r, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
